muldiv_sequencer: RTL and testbench

Multi-cycle signed multiply/divide controller that sits beside the EX-stage ALU. It sequences an iterative shift-add (multiply) or restoring shift-subtract (divide) over a fixed number of cycles. While an operation is in flight it stalls the pipeline through the hazard path. On completion it presents a two-word result: the low word goes to the destination register and the high word or remainder goes to R0, alongside the existing ALU `r0` result.

---
 rtl/muldiv_pkg.sv | 23 ++
 rtl/muldiv_step.sv | 49 ++++
 rtl/muldiv_sequencer.sv | 159 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide sequencer and the hazard unit.
package muldiv_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_PREP = 3'd1,
      ST_RUN  = 3'd2,
      ST_FIX  = 3'd3,
      ST_DONE = 3'd4
   } muldiv_state_e;

   localparam logic OP_MUL = 1'b0;
   localparam logic OP_DIV = 1'b1;

   localparam int MULDIV_WIDTH   = 16;
   // Start-to-done distance in edges; the hazard unit relies on it being constant.
   localparam int MULDIV_LATENCY = MULDIV_WIDTH + 2;

   // Divide-by-zero convention: quotient all-ones, remainder = dividend, no overflow.
   localparam logic DIV0_QUOT_BIT = 1'b1;
   localparam logic DIV0_OVF      = 1'b0;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of unsigned shift-add multiply or restoring shift-subtract divide.
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             i_op,
   input  logic [WIDTH-1:0] i_acc,
   input  logic [WIDTH-1:0] i_q,
   input  logic [WIDTH-1:0] i_m,
   output logic [WIDTH-1:0] o_acc,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_rem_sh;
   logic [WIDTH+1:0] w_diff;
   logic [WIDTH:0]   w_rem_nxt;
   logic             w_unused_rem_msb;

   // Magnitude-only arithmetic; signs are handled by the sequencer.
   always_comb begin
      w_sum            = '0;
      w_rem_sh         = '0;
      w_diff           = '0;
      w_rem_nxt        = '0;
      w_unused_rem_msb = 1'b0;
      o_acc            = i_acc;
      o_q              = i_q;
      if (i_op == OP_MUL) begin
         w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_m} : '0);
         o_acc = w_sum[WIDTH:1];
         o_q   = {w_sum[0], i_q[WIDTH-1:1]};
      end else begin
         w_rem_sh = {i_acc, i_q[WIDTH-1]};
         w_diff   = {1'b0, w_rem_sh} - {2'b00, i_m};
         // A successful subtract always leaves rem < divisor, so the MSB is dropped safely.
         if (!w_diff[WIDTH+1]) begin
            w_rem_nxt = w_diff[WIDTH:0];
            o_q       = {i_q[WIDTH-2:0], 1'b1};
         end else begin
            w_rem_nxt = w_rem_sh;
            o_q       = {i_q[WIDTH-2:0], 1'b0};
         end
         {w_unused_rem_msb, o_acc} = w_rem_nxt;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide controller beside the EX-stage ALU.
//
//  state | meaning
//  IDLE  | waiting for start
//  PREP  | operands latched; clear accumulator and counter
//  RUN   | one add/shift or subtract/shift per cycle, WIDTH cycles
//  FIX   | apply signs and special cases, load result registers
//  DONE  | results valid, done pulse; start here issues back-to-back
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             overflow_flag,
   output logic             div_zero
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   muldiv_state_e      r_state, w_state_nxt;
   logic               r_op;
   logic [WIDTH-1:0]   r_a, r_b, r_m, r_acc, r_q;
   logic [CNT_W-1:0]   r_cnt;
   logic [WIDTH-1:0]   r_result_lo, r_result_hi;
   logic               r_ovf, r_dz;

   logic               w_accept;
   logic [WIDTH-1:0]   w_mag_a, w_mag_b;
   logic [WIDTH-1:0]   w_acc_nxt, w_q_nxt;
   logic               w_neg_res, w_neg_div;
   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   logic [WIDTH-1:0]   w_quot_s, w_rem_s;
   logic               w_b_zero, w_div_ovf, w_last;

   assign w_accept  = start & ~flush & ((r_state == ST_IDLE) | (r_state == ST_DONE));
   assign w_mag_a   = operand_a[WIDTH-1] ? -operand_a : operand_a;
   assign w_mag_b   = operand_b[WIDTH-1] ? -operand_b : operand_b;
   assign w_last    = (r_cnt == CNT_W'(WIDTH-1));

   assign w_neg_res = r_a[WIDTH-1] ^ r_b[WIDTH-1];
   assign w_neg_div = r_a[WIDTH-1];
   assign w_prod    = {r_acc, r_q};
   assign w_prod_s  = w_neg_res ? -w_prod : w_prod;
   assign w_quot_s  = w_neg_res ? -r_q : r_q;
   assign w_rem_s   = w_neg_div ? -r_acc : r_acc;
   assign w_b_zero  = (r_b == '0);
   assign w_div_ovf = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .i_op  (r_op),
      .i_acc (r_acc),
      .i_q   (r_q),
      .i_m   (r_m),
      .o_acc (w_acc_nxt),
      .o_q   (w_q_nxt)
   );

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic; flush overrides everything, including a same-cycle start.
   always_comb begin
      w_state_nxt = r_state;
      if (flush) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (start) w_state_nxt = ST_PREP;
            ST_PREP: w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last) w_state_nxt = ST_FIX;
            ST_FIX:  w_state_nxt = ST_DONE;
            ST_DONE: w_state_nxt = start ? ST_PREP : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // State decodes; stall also covers the issuing cycle so the instruction is held in EX.
   always_comb begin
      busy  = (r_state == ST_PREP) | (r_state == ST_RUN) | (r_state == ST_FIX);
      done  = (r_state == ST_DONE);
      stall = w_accept | busy;
   end

   // Operand capture, iteration datapath and result registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_op        <= OP_MUL;
         r_a         <= '0;
         r_b         <= '0;
         r_m         <= '0;
         r_q         <= '0;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_result_lo <= '0;
         r_result_hi <= '0;
         r_ovf       <= 1'b0;
         r_dz        <= 1'b0;
      end else if (w_accept) begin
         r_op <= op;
         r_a  <= operand_a;
         r_b  <= operand_b;
         r_m  <= (op == OP_MUL) ? w_mag_a : w_mag_b;
         r_q  <= (op == OP_MUL) ? w_mag_b : w_mag_a;
      end else if (!flush) begin
         case (r_state)
            ST_PREP: begin
               r_acc <= '0;
               r_cnt <= '0;
            end
            ST_RUN: begin
               r_acc <= w_acc_nxt;
               r_q   <= w_q_nxt;
               r_cnt <= r_cnt + CNT_W'(1);
            end
            ST_FIX: begin
               if (r_op == OP_MUL) begin
                  r_result_lo <= w_prod_s[WIDTH-1:0];
                  r_result_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                  r_ovf       <= (w_prod_s[2*WIDTH-1:WIDTH] != {WIDTH{w_prod_s[WIDTH-1]}});
                  r_dz        <= 1'b0;
               end else if (w_b_zero) begin
                  r_result_lo <= {WIDTH{DIV0_QUOT_BIT}};
                  r_result_hi <= r_a;
                  r_ovf       <= DIV0_OVF;
                  r_dz        <= 1'b1;
               end else begin
                  r_result_lo <= w_quot_s;
                  r_result_hi <= w_rem_s;
                  r_ovf       <= w_div_ovf;
                  r_dz        <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result_lo     = r_result_lo;
   assign result_hi     = r_result_hi;
   assign overflow_flag = r_ovf;
   assign div_zero      = r_dz;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer with hand-computed expected results.
module tb_muldiv_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [15:0] operand_a = '0;
   logic [15:0] operand_b = '0;
   logic        flush = 1'b0;
   logic        busy, stall, done;
   logic [15:0] result_lo, result_hi;
   logic        overflow_flag, div_zero;

   int n_checks = 0;
   int n_fail   = 0;

   muldiv_sequencer #(.WIDTH(16)) dut (
      .clock         (clock),
      .reset         (reset),
      .start         (start),
      .op            (op),
      .operand_a     (operand_a),
      .operand_b     (operand_b),
      .flush         (flush),
      .busy          (busy),
      .stall         (stall),
      .done          (done),
      .result_lo     (result_lo),
      .result_hi     (result_hi),
      .overflow_flag (overflow_flag),
      .div_zero      (div_zero)
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   // Called at a negedge. Issues one op and returns the start-to-done edge count.
   // A start pulse with junk operands is injected at edge count poke (0 = none).
   task automatic run_op(input logic op_i, input logic [15:0] a, input logic [15:0] b,
                         input int poke, output int lat, output logic stall_ok);
      int n;
      stall_ok  = 1'b1;
      lat       = 99;
      start     = 1'b1;
      op        = op_i;
      operand_a = a;
      operand_b = b;
      #1;
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clock);
      n = 0;
      @(negedge clock);
      start = 1'b0;
      if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clock);
         n++;
         @(negedge clock);
         if (done === 1'b1) begin
            lat = n;
            if (stall !== 1'b0 || busy !== 1'b0) stall_ok = 1'b0;
            break;
         end
         if (stall !== 1'b1 || busy !== 1'b1) stall_ok = 1'b0;
         if (n == poke) begin
            start     = 1'b1;
            op        = 1'b1;
            operand_a = 16'h0001;
            operand_b = 16'h0001;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
   endtask

   task automatic op_and_check(input string tag, input logic op_i, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] exp_lo,
                               input logic [15:0] exp_hi, input logic exp_ovf,
                               input logic exp_dz, input int poke);
      int   lat;
      logic sok;
      run_op(op_i, a, b, poke, lat, sok);
      check_eq({tag, " latency"}, lat, 18);
      check_eq({tag, " stall/busy"}, sok, 1'b1);
      check_eq({tag, " lo"}, result_lo, exp_lo);
      check_eq({tag, " hi"}, result_hi, exp_hi);
      check_eq({tag, " ovf"}, overflow_flag, exp_ovf);
      check_eq({tag, " dz"}, div_zero, exp_dz);
   endtask

   task automatic idle_cycle(input string tag);
      @(posedge clock);
      @(negedge clock);
      check_eq({tag, " done pulse one cycle"}, done, 1'b0);
      check_eq({tag, " busy after done"}, busy, 1'b0);
   endtask

   task automatic count_done(input int cycles, output int seen);
      seen = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clock);
         if (done === 1'b1) seen++;
      end
   endtask

   initial begin
      int seen;
      #2;
      check_eq("rst busy", busy, 1'b0);
      check_eq("rst stall", stall, 1'b0);
      check_eq("rst done", done, 1'b0);
      check_eq("rst lo", result_lo, 16'h0000);
      check_eq("rst hi", result_hi, 16'h0000);
      check_eq("rst ovf", overflow_flag, 1'b0);
      check_eq("rst dz", div_zero, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      op_and_check("mul 7*-3", 1'b0, 16'h0007, 16'hFFFD, 16'hFFEB, 16'hFFFF, 1'b0, 1'b0, 0);
      idle_cycle("mul 7*-3");
      op_and_check("mul 4000*4", 1'b0, 16'h4000, 16'h0004, 16'h0000, 16'h0001, 1'b1, 1'b0, 0);
      idle_cycle("mul 4000*4");
      op_and_check("mul -5*-6", 1'b0, 16'hFFFB, 16'hFFFA, 16'h001E, 16'h0000, 1'b0, 1'b0, 0);
      idle_cycle("mul -5*-6");
      op_and_check("div -7/2", 1'b1, 16'hFFF9, 16'h0002, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 0);
      idle_cycle("div -7/2");
      op_and_check("div 7/-2", 1'b1, 16'h0007, 16'hFFFE, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 0);
      idle_cycle("div 7/-2");
      op_and_check("div min/-1", 1'b1, 16'h8000, 16'hFFFF, 16'h8000, 16'h0000, 1'b1, 1'b0, 0);
      idle_cycle("div min/-1");
      op_and_check("div 100/0", 1'b1, 16'h0064, 16'h0000, 16'hFFFF, 16'h0064, 1'b0, 1'b1, 0);
      idle_cycle("div 100/0");

      // Flush while the counter reads 5.
      start = 1'b1; op = 1'b0; operand_a = 16'h0002; operand_b = 16'h0003;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (6) @(posedge clock);
      @(negedge clock);
      flush = 1'b1;
      @(posedge clock);
      @(negedge clock);
      flush = 1'b0;
      check_eq("flush busy", busy, 1'b0);
      check_eq("flush stall", stall, 1'b0);
      check_eq("flush done", done, 1'b0);
      count_done(25, seen);
      check_eq("flush no done", seen, 0);
      check_eq("flush lo kept", result_lo, 16'hFFFF);
      check_eq("flush hi kept", result_hi, 16'h0064);
      check_eq("flush dz kept", div_zero, 1'b1);

      // Start together with flush in IDLE.
      start = 1'b1; flush = 1'b1; op = 1'b0; operand_a = 16'h0003; operand_b = 16'h0003;
      #1;
      check_eq("start+flush stall", stall, 1'b0);
      @(posedge clock);
      @(negedge clock);
      start = 1'b0; flush = 1'b0;
      check_eq("start+flush busy", busy, 1'b0);
      count_done(22, seen);
      check_eq("start+flush no done", seen, 0);
      check_eq("start+flush lo kept", result_lo, 16'hFFFF);

      // Back-to-back: second start issued in the DONE cycle.
      op_and_check("b2b mul 2*3", 1'b0, 16'h0002, 16'h0003, 16'h0006, 16'h0000, 1'b0, 1'b0, 0);
      op_and_check("b2b div 9/4", 1'b1, 16'h0009, 16'h0004, 16'h0002, 16'h0001, 1'b0, 1'b0, 0);
      idle_cycle("b2b");

      // Start pulsed during RUN must be ignored.
      op_and_check("poke mul 10*11", 1'b0, 16'h0010, 16'h0011, 16'h0110, 16'h0000, 1'b0, 1'b0, 5);
      idle_cycle("poke");

      // Asynchronous reset mid-RUN.
      start = 1'b1; op = 1'b0; operand_a = 16'h0005; operand_b = 16'h0005;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (8) @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      check_eq("midrst busy", busy, 1'b0);
      check_eq("midrst stall", stall, 1'b0);
      check_eq("midrst done", done, 1'b0);
      check_eq("midrst lo", result_lo, 16'h0000);
      check_eq("midrst hi", result_hi, 16'h0000);
      check_eq("midrst ovf", overflow_flag, 1'b0);
      @(negedge clock);
      reset = 1'b1;
      count_done(25, seen);
      check_eq("midrst no done", seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
